fsm_vend_multi: RTL and testbench

- Parametrised successor of the single-product drink FSM.
- Sells one of N_ITEMS products, each with its own price, and accepts 0.5/1.0 coins up to a credit ceiling.
- Returns change in half-unit counts, refunds on cancel or inactivity timeout, and flags rejected coins.
- Sits between the coin/keypad front end and the dispenser/change actuators.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/fsm_vend_multi_if.sv | 29 ++
 rtl/vend_timer.sv | 28 ++
 rtl/fsm_vend_multi.sv | 142 ++++++++++++++
 tb/tb_fsm_vend_multi.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types, coin codes and coin valuation for the multi-product vending FSM.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_H    = 2'b01;
  localparam logic [1:0] COIN_1    = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  // Half-unit value of a coin code; invalid and empty codes are worth nothing.
  function automatic logic [1:0] coin_value(input logic [1:0] code);
    logic [1:0] val;
    case (code)
      COIN_H:  val = 2'd1;
      COIN_1:  val = 2'd2;
      default: val = 2'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/fsm_vend_multi_if.sv
// Front-end/actuator bundle of the vending FSM; master is the coin/keypad side.
interface fsm_vend_multi_if #(
  parameter int unsigned N_ITEMS = 2,
  parameter int unsigned CRED_W  = 4
) ();
  localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

  logic              start_flag;
  logic [SEL_W-1:0]  item_sel;
  logic [1:0]        coin;
  logic              cancel;
  logic              working;
  logic              drink_out;
  logic [SEL_W-1:0]  drink_id;
  logic              charge_vld;
  logic [CRED_W-1:0] charge_coin;
  logic              coin_reject;
  logic [CRED_W-1:0] credit;

  modport master (
    output start_flag, item_sel, coin, cancel,
    input  working, drink_out, drink_id, charge_vld, charge_coin, coin_reject, credit
  );

  modport slave (
    input  start_flag, item_sel, coin, cancel,
    output working, drink_out, drink_id, charge_vld, charge_coin, coin_reject, credit
  );
endinterface

// File: rtl/vend_timer.sv
// Inactivity down-counter: load arms it, each enabled cycle counts down, expire_c flags zero.
module vend_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire_c
);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Loaded with TIMEOUT-1 so expiry is seen on the TIMEOUT-th enabled edge after load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(TIMEOUT - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expire_c = (cnt_q == '0);

endmodule

// File: rtl/fsm_vend_multi.sv
// Multi-product vending controller: credit accumulation, price mux, vend/refund sequencing.
module fsm_vend_multi
  import vend_pkg::*;
#(
  parameter int unsigned                N_ITEMS    = 2,
  parameter int unsigned                CRED_W     = 4,
  parameter logic [N_ITEMS*CRED_W-1:0]  PRICE_VEC  = {4'd3, 4'd5},
  parameter int unsigned                MAX_CREDIT = 10,
  parameter int unsigned                TIMEOUT    = 16
) (
  input logic             clk,
  input logic             rst,
  fsm_vend_multi_if.slave bus
);
  localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int unsigned SUM_W = CRED_W + 1;

  // Parameter sanity checks at elaboration.
  if (N_ITEMS < 1 || N_ITEMS > 8) begin : g_bad_items
    $error("N_ITEMS must be within 1..8");
  end
  if (MAX_CREDIT >= (2 ** CRED_W)) begin : g_bad_max
    $error("MAX_CREDIT must be below 2**CRED_W");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
  for (genvar g = 0; g < N_ITEMS; g++) begin : g_chk_price
    if (32'(PRICE_VEC[g*CRED_W +: CRED_W]) == 0 ||
        32'(PRICE_VEC[g*CRED_W +: CRED_W]) > MAX_CREDIT) begin : g_bad_price
      $error("every price must lie within 1..MAX_CREDIT");
    end
  end

  state_t            state;
  logic [SEL_W-1:0]  item_q;
  logic [CRED_W-1:0] credit_q;
  logic              working_q;
  logic              drink_out_q;
  logic [SEL_W-1:0]  drink_id_q;
  logic              charge_vld_q;
  logic [CRED_W-1:0] charge_coin_q;
  logic              coin_reject_q;

  logic [CRED_W-1:0] price_c;
  logic [SUM_W-1:0]  sum_c;
  logic              coin_ok_c;
  logic              start_ok_c;
  logic              accept_c;
  logic              expire_c;
  logic              tmr_load_c;
  logic              tmr_en_c;

  // Price of the latched item.
  always_comb begin
    price_c = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (item_q == SEL_W'(i)) price_c = PRICE_VEC[i*CRED_W +: CRED_W];
    end
  end

  // Coin acceptance; the sum carries an extra bit so the ceiling compare cannot wrap.
  always_comb begin
    sum_c      = {1'b0, credit_q} + SUM_W'(coin_value(bus.coin));
    coin_ok_c  = (coin_value(bus.coin) != 2'd0) && (sum_c <= SUM_W'(MAX_CREDIT));
    start_ok_c = bus.start_flag && ({1'b0, bus.item_sel} < (SEL_W + 1)'(N_ITEMS));
    accept_c   = (state == COLLECT) && !bus.cancel && !expire_c && coin_ok_c;
    tmr_load_c = ((state == IDLE) && start_ok_c) || accept_c;
    tmr_en_c   = (state == COLLECT);
  end

  vend_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_c),
    .en       (tmr_en_c),
    .expire_c (expire_c)
  );

  // Transaction FSM with registered pulses; cancel outranks timeout, which outranks coins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      item_q        <= '0;
      credit_q      <= '0;
      working_q     <= 1'b0;
      drink_out_q   <= 1'b0;
      drink_id_q    <= '0;
      charge_vld_q  <= 1'b0;
      charge_coin_q <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      drink_out_q   <= 1'b0;
      charge_vld_q  <= 1'b0;
      charge_coin_q <= '0;
      coin_reject_q <= (bus.coin != COIN_NONE) && !accept_c;
      case (state)
        IDLE: begin
          if (start_ok_c) begin
            item_q    <= bus.item_sel;
            credit_q  <= '0;
            working_q <= 1'b1;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.cancel || expire_c) begin
            charge_vld_q  <= (credit_q != '0);
            charge_coin_q <= credit_q;
            state         <= REFUND;
          end else if (accept_c) begin
            credit_q <= sum_c[CRED_W-1:0];
            if (sum_c >= {1'b0, price_c}) begin
              drink_out_q <= 1'b1;
              drink_id_q  <= item_q;
              state       <= VEND;
              if (sum_c > {1'b0, price_c}) begin
                charge_vld_q  <= 1'b1;
                charge_coin_q <= CRED_W'(sum_c - {1'b0, price_c});
              end
            end
          end
        end
        VEND, REFUND: begin
          credit_q  <= '0;
          working_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.working     = working_q;
  assign bus.drink_out   = drink_out_q;
  assign bus.drink_id    = drink_id_q;
  assign bus.charge_vld  = charge_vld_q;
  assign bus.charge_coin = charge_coin_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.credit      = credit_q;

endmodule

// File: tb/tb_fsm_vend_multi.sv
// Directed bench for fsm_vend_multi: each step queues the expected post-edge outputs.
module tb_fsm_vend_multi;
  import vend_pkg::*;

  typedef struct {
    string      tag;
    logic       w;
    logic       d;
    logic       di;
    logic       cv;
    logic [3:0] cc;
    logic       cr;
    logic [3:0] cred;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  fsm_vend_multi_if #(.N_ITEMS(2), .CRED_W(4)) bus ();

  fsm_vend_multi #(
    .N_ITEMS   (2),
    .CRED_W    (4),
    .PRICE_VEC ({4'd3, 4'd5}),
    .MAX_CREDIT(10),
    .TIMEOUT   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare against what the DUT shows now.
  task automatic check_one();
    exp_t e;
    n_assert++;
    assert (sb_q.size() != 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      cmp({e.tag, ".working"},     5'(bus.working),     5'(e.w));
      cmp({e.tag, ".drink_out"},   5'(bus.drink_out),   5'(e.d));
      if (e.d) cmp({e.tag, ".drink_id"}, 5'(bus.drink_id), 5'(e.di));
      cmp({e.tag, ".charge_vld"},  5'(bus.charge_vld),  5'(e.cv));
      cmp({e.tag, ".charge_coin"}, 5'(bus.charge_coin), 5'(e.cc));
      cmp({e.tag, ".coin_reject"}, 5'(bus.coin_reject), 5'(e.cr));
      cmp({e.tag, ".credit"},      5'(bus.credit),      5'(e.cred));
    end
  endtask

  // Drive one cycle of inputs, queue expectation, advance past the edge and check.
  task automatic step(input logic r, input logic sf, input logic sel, input logic [1:0] c,
                      input logic cn, input string tag,
                      input logic w, input logic d, input logic di, input logic cv,
                      input logic [3:0] cc, input logic cr, input logic [3:0] cred);
    exp_t e;
    rst            = r;
    bus.start_flag = sf;
    bus.item_sel   = sel;
    bus.coin       = c;
    bus.cancel     = cn;
    e.tag = tag; e.w = w; e.d = d; e.di = di; e.cv = cv; e.cc = cc; e.cr = cr; e.cred = cred;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_one();
  endtask

  initial begin
    bus.start_flag = 1'b0;
    bus.item_sel   = 1'b0;
    bus.coin       = COIN_NONE;
    bus.cancel     = 1'b0;
    #1;
    //   r  sf sel coin       cn  tag          w  d  di cv cc  cr cred
    step(1, 0, 0, COIN_NONE, 0, "reset0",     0, 0, 0, 0, 0,  0, 0);
    step(1, 0, 0, COIN_NONE, 0, "reset1",     0, 0, 0, 0, 0,  0, 0);
    step(0, 0, 0, COIN_1,    0, "idle_coin",  0, 0, 0, 0, 0,  1, 0);

    // Item 0 paid exactly: 2+2+1
    step(0, 1, 0, COIN_NONE, 0, "s1_start",   1, 0, 0, 0, 0,  0, 0);
    step(0, 0, 0, COIN_1,    0, "s1_c1",      1, 0, 0, 0, 0,  0, 2);
    step(0, 0, 0, COIN_1,    0, "s1_c2",      1, 0, 0, 0, 0,  0, 4);
    step(0, 0, 0, COIN_H,    0, "s1_c3",      1, 1, 0, 0, 0,  0, 5);
    step(0, 0, 0, COIN_NONE, 0, "s1_done",    0, 0, 0, 0, 0,  0, 0);

    // Item 0 overpaid: 2+2+2, one half-unit change; coin during VEND rejected
    step(0, 1, 0, COIN_NONE, 0, "s2_start",   1, 0, 0, 0, 0,  0, 0);
    step(0, 0, 0, COIN_1,    0, "s2_c1",      1, 0, 0, 0, 0,  0, 2);
    step(0, 0, 0, COIN_1,    0, "s2_c2",      1, 0, 0, 0, 0,  0, 4);
    step(0, 0, 0, COIN_1,    0, "s2_c3",      1, 1, 0, 1, 1,  0, 6);
    step(0, 0, 0, COIN_1,    0, "s2_vendcoin",0, 0, 0, 0, 0,  1, 0);

    // Item 1, half coin, cancel
    step(0, 1, 1, COIN_NONE, 0, "s3_start",   1, 0, 0, 0, 0,  0, 0);
    step(0, 0, 0, COIN_H,    0, "s3_c1",      1, 0, 0, 0, 0,  0, 1);
    step(0, 0, 0, COIN_NONE, 1, "s3_cancel",  1, 0, 0, 1, 1,  0, 1);
    step(0, 0, 0, COIN_NONE, 0, "s3_done",    0, 0, 0, 0, 0,  0, 0);

    // Item 0, one coin, then inactivity timeout on the 16th edge after the coin
    step(0, 1, 0, COIN_NONE, 0, "s4_start",   1, 0, 0, 0, 0,  0, 0);
    step(0, 0, 0, COIN_1,    0, "s4_c1",      1, 0, 0, 0, 0,  0, 2);
    for (int i = 1; i < 16; i++) begin
      step(0, 0, 0, COIN_NONE, 0, $sformatf("s4_wait%0d", i), 1, 0, 0, 0, 0, 0, 2);
    end
    step(0, 0, 0, COIN_NONE, 0, "s4_timeout", 1, 0, 0, 1, 2,  0, 2);
    step(0, 0, 0, COIN_NONE, 0, "s4_done",    0, 0, 0, 0, 0,  0, 0);

    // Item 1: cancel with a simultaneous coin; start during COLLECT ignored
    step(0, 1, 1, COIN_NONE, 0, "s5_start",   1, 0, 0, 0, 0,  0, 0);
    step(0, 1, 0, COIN_1,    0, "s5_c1",      1, 0, 0, 0, 0,  0, 2);
    step(0, 0, 0, COIN_1,    1, "s5_cancel",  1, 0, 0, 1, 2,  1, 2);
    step(0, 0, 0, COIN_NONE, 0, "s5_done",    0, 0, 0, 0, 0,  0, 0);

    // Item 1: invalid coins rejected without changing credit, exact payment
    step(0, 1, 1, COIN_NONE, 0, "s6_start",   1, 0, 0, 0, 0,  0, 0);
    step(0, 0, 0, COIN_BAD,  0, "s6_bad0",    1, 0, 0, 0, 0,  1, 0);
    step(0, 0, 0, COIN_H,    0, "s6_c1",      1, 0, 0, 0, 0,  0, 1);
    step(0, 0, 0, COIN_BAD,  0, "s6_bad1",    1, 0, 0, 0, 0,  1, 1);
    step(0, 0, 0, COIN_1,    0, "s6_c2",      1, 1, 1, 0, 0,  0, 3);
    step(0, 0, 0, COIN_NONE, 0, "s6_done",    0, 0, 0, 0, 0,  0, 0);

    // Item 0: reset mid-transaction discards credit, no refund afterwards
    step(0, 1, 0, COIN_NONE, 0, "s7_start",   1, 0, 0, 0, 0,  0, 0);
    step(0, 0, 0, COIN_1,    0, "s7_c1",      1, 0, 0, 0, 0,  0, 2);
    step(0, 0, 0, COIN_1,    0, "s7_c2",      1, 0, 0, 0, 0,  0, 4);
    step(1, 0, 0, COIN_NONE, 0, "s7_rst",     0, 0, 0, 0, 0,  0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, COIN_NONE, 0, $sformatf("s7_after%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
